// File: rtl/hazard_unit.sv
// ============================================================================
// Module   : hazard_unit
// Brief    : Pipeline stall/flush controller with exception-mask FSM and
//            saturating stall/flush performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int CNT_W        = 16,
    parameter int EXC_MASK_CYC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_jr,
    input  logic             id_jump,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rt,
    input  logic             ex_regwr,
    input  logic [4:0]       ex_wr_addr,
    input  logic             mem_memrd,
    input  logic [4:0]       mem_wr_addr,
    input  logic             ex_branch_taken,
    input  logic             exc_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_hazard,
    output logic             idex_special_hazard,
    output logic             exmem_flush,
    output logic             pc_src_exc,
    output logic             mask_active,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        EXC_MASK = 1'b1
    } state_t;

    localparam logic [3:0] c_mask_init = 4'(EXC_MASK_CYC - 1);

    state_t           r_state;
    logic [3:0]       r_mcnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic w_lu;
    logic w_jrh;
    logic w_stall;
    logic w_p1;
    logic w_p2;
    logic w_p3;
    logic w_p4;

    assign w_lu = ex_memrd && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign w_jrh = id_is_jr &&
                   ((ex_regwr  && (ex_wr_addr  != 5'd0) && (ex_wr_addr  == id_rs)) ||
                    (mem_memrd && (mem_wr_addr != 5'd0) && (mem_wr_addr == id_rs)));

    assign w_stall = w_lu || w_jrh;

    // Priority decode; gated by reset so nothing advances while it is held.
    assign w_p1 = reset && (r_state == RUN) && exc_req;
    assign w_p2 = reset && !w_p1 && ex_branch_taken;
    assign w_p3 = reset && !w_p1 && !w_p2 && w_stall;
    assign w_p4 = reset && !w_p1 && !w_p2 && !w_p3 && id_jump;

    always_comb begin
        pc_write            = 1'b0;
        ifid_write          = 1'b0;
        ifid_flush          = 1'b0;
        idex_hazard         = 1'b0;
        idex_special_hazard = 1'b0;
        exmem_flush         = 1'b0;
        pc_src_exc          = 1'b0;
        if (reset) begin
            if (w_p1) begin
                ifid_flush          = 1'b1;
                idex_special_hazard = 1'b1;
                exmem_flush         = 1'b1;
                pc_src_exc          = 1'b1;
                pc_write            = 1'b1;
                ifid_write          = 1'b1;
            end else if (w_p2) begin
                ifid_flush          = 1'b1;
                idex_special_hazard = 1'b1;
                pc_write            = 1'b1;
                ifid_write          = 1'b1;
            end else if (w_p3) begin
                idex_hazard         = 1'b1;
            end else if (w_p4) begin
                ifid_flush          = 1'b1;
                pc_write            = 1'b1;
                ifid_write          = 1'b1;
            end else begin
                pc_write            = 1'b1;
                ifid_write          = 1'b1;
            end
        end
    end

    assign mask_active  = reset && (r_state == EXC_MASK);
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= RUN;
            r_mcnt         <= 4'd0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (exc_req) begin
                        r_state <= EXC_MASK;
                        r_mcnt  <= c_mask_init;
                    end
                end
                EXC_MASK: begin
                    if (r_mcnt != 4'd0) begin
                        r_mcnt <= r_mcnt - 4'd1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_mcnt  <= 4'd0;
                end
            endcase

            if (w_p3 && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if ((w_p1 || w_p2 || w_p4) && !(&r_flush_events)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module   : tb_hazard_unit
// Brief    : Directed self-checking bench for hazard_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_is_jr;
    logic             id_jump;
    logic             ex_memrd;
    logic [4:0]       ex_rt;
    logic             ex_regwr;
    logic [4:0]       ex_wr_addr;
    logic             mem_memrd;
    logic [4:0]       mem_wr_addr;
    logic             ex_branch_taken;
    logic             exc_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_hazard;
    logic             idex_special_hazard;
    logic             exmem_flush;
    logic             pc_src_exc;
    logic             mask_active;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    int n_chk;
    int n_pass;

    hazard_unit #(.CNT_W(CNT_W), .EXC_MASK_CYC(3)) dut (
        .clk                 (clk),
        .reset               (reset),
        .id_rs               (id_rs),
        .id_rt               (id_rt),
        .id_uses_rt          (id_uses_rt),
        .id_is_jr            (id_is_jr),
        .id_jump             (id_jump),
        .ex_memrd            (ex_memrd),
        .ex_rt               (ex_rt),
        .ex_regwr            (ex_regwr),
        .ex_wr_addr          (ex_wr_addr),
        .mem_memrd           (mem_memrd),
        .mem_wr_addr         (mem_wr_addr),
        .ex_branch_taken     (ex_branch_taken),
        .exc_req             (exc_req),
        .pc_write            (pc_write),
        .ifid_write          (ifid_write),
        .ifid_flush          (ifid_flush),
        .idex_hazard         (idex_hazard),
        .idex_special_hazard (idex_special_hazard),
        .exmem_flush         (exmem_flush),
        .pc_src_exc          (pc_src_exc),
        .mask_active         (mask_active),
        .stall_cycles        (stall_cycles),
        .flush_events        (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_hazard,
    //  idex_special_hazard, exmem_flush, pc_src_exc, mask_active}
    function automatic logic [7:0] ctrl();
        return {pc_write, ifid_write, ifid_flush, idex_hazard,
                idex_special_hazard, exmem_flush, pc_src_exc, mask_active};
    endfunction

    localparam logic [7:0] C_IDLE   = 8'b1100_0000;
    localparam logic [7:0] C_STALL  = 8'b0001_0000;
    localparam logic [7:0] C_BRANCH = 8'b1110_1000;
    localparam logic [7:0] C_JUMP   = 8'b1110_0000;
    localparam logic [7:0] C_EXC    = 8'b1110_1110;
    localparam logic [7:0] C_MASK   = 8'b1100_0001;
    localparam logic [7:0] C_ZERO   = 8'b0000_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_is_jr = 1'b0;
        id_jump = 1'b0; ex_memrd = 1'b0; ex_rt = 5'd0; ex_regwr = 1'b0;
        ex_wr_addr = 5'd0; mem_memrd = 1'b0; mem_wr_addr = 5'd0;
        ex_branch_taken = 1'b0; exc_req = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        idle_inputs();
        #2;
        chk("reset_ctrl", 32'(ctrl()), 32'(C_ZERO));
        chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("reset_flush_cnt", 32'(flush_events), 32'd0);

        next();
        reset = 1'b1;
        #1;
        chk("idle_ctrl", 32'(ctrl()), 32'(C_IDLE));
        next();

        // Load-use on rs
        ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_rs_ctrl", 32'(ctrl()), 32'(C_STALL));
        next();
        chk("lu_rs_stall_cnt", 32'(stall_cycles), 32'd1);

        // Register 0 never hazards
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0_ctrl", 32'(ctrl()), 32'(C_IDLE));
        next();

        // Load-use on rt when rt is a source, none when it is not
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_ctrl", 32'(ctrl()), 32'(C_STALL));
        next();
        id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused_ctrl", 32'(ctrl()), 32'(C_IDLE));
        next();
        chk("lu_rt_stall_cnt", 32'(stall_cycles), 32'd2);

        // Taken branch overrides a simultaneous load-use
        id_rs = 5'd7; ex_branch_taken = 1'b1;
        #1;
        chk("branch_vs_stall_ctrl", 32'(ctrl()), 32'(C_BRANCH));
        next();
        chk("branch_flush_cnt", 32'(flush_events), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cycles), 32'd2);

        // Jump alone flushes IF/ID; stall beats jump
        idle_inputs();
        id_jump = 1'b1;
        #1;
        chk("jump_ctrl", 32'(ctrl()), 32'(C_JUMP));
        next();
        ex_memrd = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        #1;
        chk("jump_vs_stall_ctrl", 32'(ctrl()), 32'(C_STALL));
        next();
        chk("jump_flush_cnt", 32'(flush_events), 32'd2);
        chk("jump_stall_cnt", 32'(stall_cycles), 32'd3);

        // jr r8 behind a load to r8: two stall cycles then proceed
        idle_inputs();
        id_is_jr = 1'b1; id_rs = 5'd8;
        ex_memrd = 1'b1; ex_rt = 5'd8; ex_regwr = 1'b1; ex_wr_addr = 5'd8;
        #1;
        chk("jr_load_c1_ctrl", 32'(ctrl()), 32'(C_STALL));
        next();
        ex_memrd = 1'b0; ex_rt = 5'd0; ex_regwr = 1'b0; ex_wr_addr = 5'd0;
        mem_memrd = 1'b1; mem_wr_addr = 5'd8;
        #1;
        chk("jr_load_c2_ctrl", 32'(ctrl()), 32'(C_STALL));
        next();
        mem_memrd = 1'b0; mem_wr_addr = 5'd0;
        #1;
        chk("jr_load_c3_ctrl", 32'(ctrl()), 32'(C_IDLE));
        next();
        chk("jr_load_stall_cnt", 32'(stall_cycles), 32'd5);

        // jr behind an ALU writer in EX; non-jr with same operands is clean
        ex_regwr = 1'b1; ex_wr_addr = 5'd9; id_rs = 5'd9;
        #1;
        chk("jr_alu_ctrl", 32'(ctrl()), 32'(C_STALL));
        id_is_jr = 1'b0;
        #1;
        chk("nonjr_alu_ctrl", 32'(ctrl()), 32'(C_IDLE));
        next();

        // Exception then three masked cycles that ignore exc_req
        idle_inputs();
        exc_req = 1'b1;
        #1;
        chk("exc_ctrl", 32'(ctrl()), 32'(C_EXC));
        next();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mask_c%0d_ctrl", i), 32'(ctrl()), 32'(C_MASK));
            next();
        end
        chk("mask_flush_cnt", 32'(flush_events), 32'd3);
        #1;
        chk("exc_after_mask_ctrl", 32'(ctrl()), 32'(C_EXC));
        next();
        chk("exc2_flush_cnt", 32'(flush_events), 32'd4);
        exc_req = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        chk("mask_branch_ctrl", 32'(ctrl()), 32'(C_BRANCH | 8'b0000_0001));

        // Asynchronous reset in the middle of the mask window
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'(ctrl()), 32'(C_ZERO));
        chk("async_rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("async_rst_flush_cnt", 32'(flush_events), 32'd0);
        next();
        idle_inputs();
        reset = 1'b1;
        exc_req = 1'b1;
        #1;
        chk("post_rst_run_exc_ctrl", 32'(ctrl()), 32'(C_EXC));
        #1;
        exc_req = 1'b0;
        reset = 1'b0;
        next();
        reset = 1'b1;

        // Stall counter saturation
        ex_memrd = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall_cnt", 32'(stall_cycles), 32'h0000_FFFF);
        next();
        chk("sat_hold_stall_cnt", 32'(stall_cycles), 32'h0000_FFFF);
        chk("sat_flush_cnt", 32'(flush_events), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
